dm_access_ctrl: RTL and testbench
=================================

// Module: dm_access_ctrl
// PURPOSE
//  Sequences every MEM-stage access to the 4 KB word-wide data memory (dm_4k).
//  Word loads/stores pass through in one cycle. Byte/halfword stores run as a
//  2-cycle read-modify-write (RMW) with a pipeline stall. Sub-word loads are
//  extracted and extended. Address range and alignment are checked before any write.
// PARAMETERS
//  BASE_ADDR   32'h1001_0000  byte address of dm word 0
//  DEPTH_WORDS 1024           dm depth in 32-bit words (4 KB)
//  CNT_W       16             width of saturating RMW event counter
// PORTS
//  clock       in   1   rising-edge clock
//  reset       in   1   asynchronous, active-high reset
//  req_valid   in   1   MEM stage has a memory op this cycle
//  req_we      in   1   1 = store, 0 = load
//  req_size    in   2   00 byte, 01 half, 10 word, 11 illegal (treated as range error)
//  req_signed  in   1   loads: 1 = sign-extend, 0 = zero-extend
//  req_addr    in   32  byte address (from ALU result)
//  req_wdata   in   32  store data, right-justified
//  stall       out  1   hold pipeline; requester keeps all req_* stable
//  rdata       out  32  extended load data (combinational)
//  err_align   out  1   registered 1-cycle pulse: misaligned access
//  err_range   out  1   registered 1-cycle pulse: address outside dm or size 11
//  rmw_count   out  CNT_W  completed sub-word stores, saturating
//  mem_addr    out  32  to dm address input (word-aligned: low 2 bits 0)
//  mem_wdata   out  32  to dm write data
//  mem_we      out  1   to dm MemWrite
//  mem_rdata   in   32  dm read data (combinational read of mem_addr)
// BEHAVIOUR
//  Reset: state=IDLE, err_* = 0, rmw_count = 0, merge reg = 0. While reset
//   is high: mem_we = 0 and stall = 0 (combinational force).
//  off = req_addr - BASE_ADDR.
//   Range error if off >= 4*DEPTH_WORDS (unsigned) or req_size = 11.
//   Align error if (half and addr[0]) or (word and addr[1:0] != 0).
//   Range error takes priority; only one err bit pulses per request.
//  Error request: mem_we = 0, stall = 0, rdata = 0. The err bit pulses on the
//   next cycle for exactly 1 cycle. No state change.
//  mem_addr = {req_addr[31:2], 2'b00} whenever req_valid, else 0.
//  FSM states: IDLE, RMW_WR.
//   IDLE, no req or load: mem_we = 0, stall = 0.
//    Load rdata = selected byte/half of mem_rdata (lane = addr[1:0]), extended.
//   IDLE, word store: mem_we = 1, mem_wdata = req_wdata, stall = 0; stay IDLE.
//   IDLE, byte/half store: stall = 1, mem_we = 0.
//    Merge reg <= mem_rdata with req_wdata[7:0] or [15:0] inserted at the lane.
//    Next state is RMW_WR.
//   RMW_WR: mem_we = 1, mem_wdata = merge reg, stall = 0. rmw_count++ (sat at
//    all-ones). Next state is IDLE. The request is retired this cycle.
//  Byte lanes are little-endian: lane 0 = bits [7:0]. Half at addr[1]=1 is [31:16].
//  Reset asserted in RMW_WR: write suppressed, state -> IDLE, merge reg cleared.
//  req_valid dropping in RMW_WR (protocol violation): write still completes from
//   the merge reg using the captured address.
//   Implementation keeps a copy of the word address in a register.
//  Store latency: word 1 cycle; byte/half 2 cycles (1 stall cycle).
//  Load latency: 0 (same cycle).
// TESTING
//  1 sw 0x1001_0000 <- 0x0000_0003: mem_we=1 same cycle, stall=0;
//    then lw returns 0x0000_0003.
//  2 Word = 0x1122_3344 at 0x1001_0004; sb 0xAA to 0x1001_0005:
//    stall=1 for 1 cycle, then mem_wdata=0x1122_AA44 with mem_we=1;
//    rmw_count=1.
//  3 With word 0x80FF_7F01 stored: lb@+0 = 0x0000_0001; lb@+1 = 0x0000_007F;
//    lbu@+2 = 0x0000_00FF; lh@+2 = 0xFFFF_80FF.
//  4 sh to 0x1001_0001 -> err_align pulses 1 cycle later, no mem_we.
//    sw to 0x1001_1000 -> err_range pulses, no mem_we.
//  5 sh 0xBEEF to 0x1001_0002 with reset raised during RMW_WR -> no write,
//    word unchanged. After reset release: state IDLE, rmw_count=0.
//  6 Back-to-back sb, sb, sw -> two 1-cycle stalls, 5 total cycles,
//    all three writes correct; counter saturates at 16'hFFFF under forced preload.

Source files
------------

// File: rtl/dm_access_ctrl.sv
// -----------------------------------------------------------------------------
// dm_access_ctrl
//   Sequences every MEM-stage access to the 4 KB word-wide data memory.
//   Word loads/stores pass straight through in one cycle. Byte/halfword stores
//   become a two-cycle read-modify-write: the first cycle stalls the pipeline
//   and merges the new lane into the word read back from memory, the second
//   cycle writes the merged word. Sub-word loads are extracted and extended.
//   Range and alignment are checked before anything is written.
//
// Handshake: req_valid qualifies all req_* inputs for the current cycle. While
//   stall is high the requester holds req_* unchanged; the request is retired
//   in the first cycle where stall is low. If req_valid drops while the write
//   half of an RMW is pending, the write still completes from the captured
//   word address and merged data.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   req_valid/we/size/    memory request from the MEM stage
//   signed/addr/wdata
//   stall                 hold the pipeline (RMW first cycle)
//   rdata                 extended load data, combinational
//   err_align, err_range  registered one-cycle error pulses
//   rmw_count             saturating count of completed sub-word stores
//   mem_addr/wdata/we     to the data memory
//   mem_rdata             data memory combinational read of mem_addr
//   dbg_rmw               FSM state for observation: 1 = RMW write cycle
// -----------------------------------------------------------------------------
module dm_access_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             stall,
    output logic [31:0]      rdata,
    output logic             err_align,
    output logic             err_range,
    output logic [CNT_W-1:0] rmw_count,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             mem_we,
    input  logic [31:0]      mem_rdata,
    output logic             dbg_rmw
);

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_e;

    localparam logic [1:0]  SZ_BYTE  = 2'b00;
    localparam logic [1:0]  SZ_HALF  = 2'b01;
    localparam logic [1:0]  SZ_WORD  = 2'b10;
    localparam logic [31:0] DM_BYTES = 32'(4 * DEPTH_WORDS);

    state_e           state_q, state_d;
    logic [31:0]      merge_q, merge_d;
    logic [29:0]      addr_q, addr_d;      // word address of the pending RMW
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_align_q, err_align_d;
    logic             err_range_q, err_range_d;

    logic [31:0] off;
    logic        range_bad;
    logic        align_bad;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Unsigned compare: addresses below BASE_ADDR wrap to huge offsets.
    assign off       = req_addr - BASE_ADDR;
    assign range_bad = (off >= DM_BYTES) || (req_size == 2'b11);
    assign align_bad = ((req_size == SZ_HALF) && req_addr[0]) ||
                       ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

    // Little-endian lanes: lane 0 is bits [7:0], upper half is [31:16].
    assign byte_sel = 8'(mem_rdata >> {req_addr[1:0], 3'b000});
    assign half_sel = req_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_ext = 32'h0;
        case (req_size)
            SZ_BYTE: load_ext = req_signed ? {{24{byte_sel[7]}}, byte_sel}
                                           : {24'h0, byte_sel};
            SZ_HALF: load_ext = req_signed ? {{16{half_sel[15]}}, half_sel}
                                           : {16'h0, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        merged = mem_rdata;
        if (req_size == SZ_HALF) begin
            if (req_addr[1]) merged[31:16] = req_wdata[15:0];
            else             merged[15:0]  = req_wdata[15:0];
        end else begin
            case (req_addr[1:0])
                2'd0:    merged[7:0]   = req_wdata[7:0];
                2'd1:    merged[15:8]  = req_wdata[7:0];
                2'd2:    merged[23:16] = req_wdata[7:0];
                default: merged[31:24] = req_wdata[7:0];
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        merge_d     = merge_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        err_align_d = 1'b0;
        err_range_d = 1'b0;
        stall       = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = 32'h0;
        rdata       = 32'h0;
        mem_addr    = req_valid ? {req_addr[31:2], 2'b00} : 32'h0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (range_bad) begin
                        err_range_d = 1'b1;
                    end else if (align_bad) begin
                        err_align_d = 1'b1;
                    end else if (!req_we) begin
                        rdata = load_ext;
                    end else if (req_size == SZ_WORD) begin
                        mem_we    = 1'b1;
                        mem_wdata = req_wdata;
                    end else begin
                        stall   = 1'b1;
                        merge_d = merged;
                        addr_d  = req_addr[31:2];
                        state_d = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                // Uses the captured address so a dropped req_valid still
                // writes the right word.
                mem_addr  = {addr_q, 2'b00};
                mem_we    = 1'b1;
                mem_wdata = merge_q;
                if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset must never let a write or stall escape, even mid-RMW.
        if (reset) begin
            mem_we = 1'b0;
            stall  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            merge_q     <= 32'h0;
            addr_q      <= 30'h0;
            cnt_q       <= '0;
            err_align_q <= 1'b0;
            err_range_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            merge_q     <= merge_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            err_align_q <= err_align_d;
            err_range_q <= err_range_d;
        end
    end

    assign err_align = err_align_q;
    assign err_range = err_range_q;
    assign rmw_count = cnt_q;
    assign dbg_rmw   = (state_q == RMW_WR);

endmodule

// File: tb/tb_dm_access_ctrl.sv
module tb_dm_access_ctrl;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        stall;
    logic [31:0] rdata;
    logic        err_align;
    logic        err_range;
    logic [15:0] rmw_count;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        dbg_rmw;

    // Narrow-counter twin, fed the same requests, to reach saturation quickly.
    logic        s_stall, s_err_align, s_err_range, s_mem_we, s_dbg_rmw;
    logic [31:0] s_rdata, s_mem_addr, s_mem_wdata;
    logic [1:0]  s_rmw_count;

    always #5 clock = ~clock;

    dm_access_ctrl dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(stall), .rdata(rdata),
        .err_align(err_align), .err_range(err_range), .rmw_count(rmw_count),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .dbg_rmw(dbg_rmw)
    );

    dm_access_ctrl #(.CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(s_stall), .rdata(s_rdata),
        .err_align(s_err_align), .err_range(s_err_range), .rmw_count(s_rmw_count),
        .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_we(s_mem_we),
        .mem_rdata(mem_rdata), .dbg_rmw(s_dbg_rmw)
    );

    // Data memory model: combinational read, synchronous write.
    logic [31:0] mem [0:1023] = '{default: 32'h0};
    logic [31:0] mem_off;
    assign mem_off   = mem_addr - BASE;
    assign mem_rdata = mem[mem_off[11:2]];
    always @(posedge clock) if (mem_we) mem[mem_off[11:2]] <= mem_wdata;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference model state
    logic [31:0] ref_mem [0:1023];
    int unsigned ref_cnt = 0;
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic [31:0] wd);
        logic [7:0] b [4];
        int n;
        for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        for (int i = 0; i < n; i++) b[int'(lane) + i] = wd[8*i +: 8];
        return {b[3], b[2], b[1], b[0]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [1:0] size, input logic sgn);
        longint v = 0;
        int n;
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        for (int i = 0; i < n; i++) v += longint'(word[8*(int'(lane) + i) +: 8]) << (8 * i);
        if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    function automatic logic [31:0] sat(input int unsigned n, input int unsigned mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic drive(input logic v, input logic we, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wd);
        req_valid = v; req_we = we; req_size = size;
        req_signed = sgn; req_addr = addr; req_wdata = wd;
    endtask

    // One complete request; checks every observable against the reference.
    task automatic do_op(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] o_rdata, output logic [31:0] o_wdata);
        logic [31:0] off, exp_w;
        logic rng, aln;
        off = addr - BASE;
        rng = (off >= 32'd4096) || (size == 2'b11);
        aln = !rng && (((size == 2'b01) && addr[0]) || ((size == 2'b10) && (addr[1:0] != 2'b00)));
        @(posedge clock); #1;
        drive(1'b1, we, size, sgn, addr, wd);
        #4;
        o_rdata = rdata; o_wdata = mem_wdata;
        chk("err_align_quiet", {31'h0, err_align}, 32'h0);
        chk("err_range_quiet", {31'h0, err_range}, 32'h0);
        chk("rmw_count", {16'h0, rmw_count}, sat(ref_cnt, 65535));
        chk("rmw_count_sat", {30'h0, s_rmw_count}, sat(ref_cnt, 3));
        chk("state_idle", {31'h0, dbg_rmw}, 32'h0);
        chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
        if (rng || aln) begin
            chk("err_we", {31'h0, mem_we}, 32'h0);
            chk("err_stall", {31'h0, stall}, 32'h0);
            chk("err_rdata", rdata, 32'h0);
            @(posedge clock); #1;
            req_valid = 1'b0;
            #4;
            chk("err_range_pulse", {31'h0, err_range}, {31'h0, rng});
            chk("err_align_pulse", {31'h0, err_align}, {31'h0, aln});
            chk("idle_addr", mem_addr, 32'h0);
        end else if (!we) begin
            chk("load_rdata", rdata, ref_load(ref_mem[off[11:2]], addr[1:0], size, sgn));
            chk("load_we", {31'h0, mem_we}, 32'h0);
            chk("load_stall", {31'h0, stall}, 32'h0);
        end else if (size == 2'b10) begin
            chk("sw_we", {31'h0, mem_we}, 32'h1);
            chk("sw_stall", {31'h0, stall}, 32'h0);
            chk("sw_wdata", mem_wdata, wd);
            ref_mem[off[11:2]] = wd;
        end else begin
            chk("rmw_stall", {31'h0, stall}, 32'h1);
            chk("rmw_rd_we", {31'h0, mem_we}, 32'h0);
            exp_w = ref_store(ref_mem[off[11:2]], addr[1:0], size, wd);
            @(posedge clock); #5;
            o_wdata = mem_wdata;
            chk("rmw_state", {31'h0, dbg_rmw}, 32'h1);
            chk("rmw_wr_stall", {31'h0, stall}, 32'h0);
            chk("rmw_wr_we", {31'h0, mem_we}, 32'h1);
            chk("rmw_wdata", mem_wdata, exp_w);
            chk("rmw_addr", mem_addr, {addr[31:2], 2'b00});
            ref_mem[off[11:2]] = exp_w;
            ref_cnt++;
        end
    endtask

    task automatic idle_cycle();
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    logic [31:0] r, w;
    int c0;

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;

        // Reset state
        repeat (3) @(posedge clock);
        #5;
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_we", {31'h0, mem_we}, 32'h0);
        chk("rst_cnt", {16'h0, rmw_count}, 32'h0);
        chk("rst_err", {30'h0, err_align, err_range}, 32'h0);
        chk("rst_state", {31'h0, dbg_rmw}, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Word store then word load
        do_op(1'b1, 2'b10, 1'b0, 32'h1001_0000, 32'h0000_0003, r, w);
        do_op(1'b0, 2'b10, 1'b0, 32'h1001_0000, 32'h0, r, w);
        chk("t1_lw", r, 32'h0000_0003);

        // Byte store into an existing word
        do_op(1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'h1122_3344, r, w);
        do_op(1'b1, 2'b00, 1'b0, 32'h1001_0005, 32'h0000_00AA, r, w);
        chk("t2_merge", w, 32'h1122_AA44);
        do_op(1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0, r, w);
        chk("t2_cnt", {16'h0, rmw_count}, 32'h1);

        // Sub-word loads with extension
        do_op(1'b1, 2'b10, 1'b0, 32'h1001_0008, 32'h80FF_7F01, r, w);
        do_op(1'b0, 2'b00, 1'b1, 32'h1001_0008, 32'h0, r, w);
        chk("t3_lb0", r, 32'h0000_0001);
        do_op(1'b0, 2'b00, 1'b1, 32'h1001_0009, 32'h0, r, w);
        chk("t3_lb1", r, 32'h0000_007F);
        do_op(1'b0, 2'b00, 1'b0, 32'h1001_000A, 32'h0, r, w);
        chk("t3_lbu2", r, 32'h0000_00FF);
        do_op(1'b0, 2'b01, 1'b1, 32'h1001_000A, 32'h0, r, w);
        chk("t3_lh2", r, 32'hFFFF_80FF);

        // Errors: misaligned half, out-of-range word, below base, illegal size
        do_op(1'b1, 2'b01, 1'b0, 32'h1001_0001, 32'h1234, r, w);
        do_op(1'b1, 2'b10, 1'b0, 32'h1001_1000, 32'h5555_5555, r, w);
        do_op(1'b1, 2'b10, 1'b0, 32'h1000_FFFC, 32'h6666_6666, r, w);
        do_op(1'b0, 2'b11, 1'b0, 32'h1001_0000, 32'h0, r, w);
        do_op(1'b1, 2'b10, 1'b0, 32'h1001_0FFC, 32'hCAFE_F00D, r, w);

        // Reset during RMW write cycle suppresses the write
        do_op(1'b1, 2'b10, 1'b0, 32'h1001_0010, 32'h0102_0304, r, w);
        @(posedge clock); #1;
        drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h1001_0012, 32'h0000_BEEF);
        #4;
        chk("t5_stall", {31'h0, stall}, 32'h1);
        @(posedge clock); #1;
        reset = 1'b1;
        #4;
        chk("t5_no_we", {31'h0, mem_we}, 32'h0);
        chk("t5_state", {31'h0, dbg_rmw}, 32'h0);
        @(posedge clock); #1;
        req_valid = 1'b0;
        reset = 1'b0;
        ref_cnt = 0;
        #4;
        chk("t5_cnt", {16'h0, rmw_count}, 32'h0);
        chk("t5_word", mem[4], 32'h0102_0304);

        // Back-to-back sb, sb, sw: five cycles in total
        c0 = cyc;
        do_op(1'b1, 2'b00, 1'b0, 32'h1001_0020, 32'h0000_0011, r, w);
        do_op(1'b1, 2'b00, 1'b0, 32'h1001_0023, 32'h0000_0022, r, w);
        do_op(1'b1, 2'b10, 1'b0, 32'h1001_0024, 32'h3333_4444, r, w);
        chk("t6_cycles", 32'(cyc - c0), 32'd5);

        // Protocol violation: req_valid drops during the RMW write
        @(posedge clock); #1;
        drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h1001_0022, 32'h0000_0099);
        @(posedge clock); #1;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h1001_0300, 32'h0);
        #4;
        chk("pv_we", {31'h0, mem_we}, 32'h1);
        chk("pv_addr", mem_addr, 32'h1001_0020);
        chk("pv_wdata", mem_wdata, 32'h2299_0011);
        ref_mem[8] = 32'h2299_0011;
        ref_cnt++;

        // Randomized traffic against the reference model
        for (int i = 0; i < 250; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? $urandom : BASE + $urandom_range(0, 4095);
            do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), a, $urandom, r, w);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();
        @(posedge clock); #5;
        chk("final_cnt", {16'h0, rmw_count}, sat(ref_cnt, 65535));
        chk("final_cnt_sat", {30'h0, s_rmw_count}, sat(ref_cnt, 3));
        for (int i = 0; i < 1024; i++) chk("mem_image", mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
